// File: rtl/pc_stall_sequencer.sv
// PC stall sequencer: holds the PC during multi-cycle mul/div and memory waits, buffering
// redirects until release. Define MISALIGN_TRAP_EN to replace misaligned targets with TRAP_VECTOR.
module pc_stall_sequencer #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        IsDiv,
  input  logic        MemWait,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic        Busy,
  output logic        PCSrc,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Trap
);

  localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] sel_addr;
  logic        misaligned;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StExec;
          cnt_d   = IsDiv ? DivLoad : MulLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StExec: begin
        if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
        else               state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Busy = (state_q == StExec) | MemWait;
  assign Done = (state_q == StDone);

  // A live redirect is younger than anything pending, so it wins both while held and at release.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (Busy) begin
      if (Redirect) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = Target;
      end
    end else begin
      pend_vld_d = 1'b0;
    end
  end

  assign PCSrc    = ~Busy & (Redirect | pend_vld_q);
  assign sel_addr = Redirect ? Target : pend_tgt_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (sel_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign Trap   = PCSrc & misaligned;
  assign Result = !PCSrc    ? 32'd0       :
                  misaligned ? TRAP_VECTOR : sel_addr;

endmodule

// File: tb/tb_pc_stall_sequencer.sv
// Directed self-checking bench for pc_stall_sequencer (default parameters).
module tb_pc_stall_sequencer;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic        IsDiv;
  logic        MemWait;
  logic        Redirect;
  logic [31:0] Target;
  logic        Busy;
  logic        PCSrc;
  logic [31:0] Result;
  logic        Done;
  logic        Trap;

  int checks = 0;
  int errors = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] ExpMisResult = 32'h0000_0100;
  localparam logic        ExpMisTrap   = 1'b1;
`else
  localparam logic [31:0] ExpMisResult = 32'h0000_0042;
  localparam logic        ExpMisTrap   = 1'b0;
`endif

  pc_stall_sequencer dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .IsDiv    (IsDiv),
    .MemWait  (MemWait),
    .Redirect (Redirect),
    .Target   (Target),
    .Busy     (Busy),
    .PCSrc    (PCSrc),
    .Result   (Result),
    .Done     (Done),
    .Trap     (Trap)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; IsDiv = 1'b0; MemWait = 1'b0; Redirect = 1'b0; Target = 32'd0;
    #3;
    checks++;
    if ({Busy, PCSrc, Done, Trap} !== 4'b0000 || Result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy/pcsrc/done/trap=%b result=%h, want 0000 result=0",
               {Busy, PCSrc, Done, Trap}, Result);
    end
    MemWait = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_memwait: got %b want 1", Busy);
    end
    MemWait = 1'b0;
    step; step;
    Reset = 1'b0;
  endtask

  task automatic test_mul;
    step;
    Start = 1'b1; IsDiv = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_issue_busy: got %b want 0", Busy);
    end
    step;
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({Busy, Done, PCSrc} !== 3'b100) begin
        errors++;
        $display("FAIL mul_exec_%0d: got busy/done/pcsrc=%b want 100", i, {Busy, Done, PCSrc});
      end
      step;
    end
    @(negedge CLK);
    checks++;
    if ({Busy, Done, PCSrc} !== 3'b010) begin
      errors++;
      $display("FAIL mul_done: got busy/done/pcsrc=%b want 010", {Busy, Done, PCSrc});
    end
    step;
    @(negedge CLK);
    checks++;
    if ({Busy, Done, PCSrc} !== 3'b000) begin
      errors++;
      $display("FAIL mul_after: got busy/done/pcsrc=%b want 000", {Busy, Done, PCSrc});
    end
  endtask

  task automatic test_div_redirect;
    step;
    Start = 1'b1; IsDiv = 1'b1;
    step;
    Start = 1'b0; IsDiv = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      Redirect = (i == 3) || (i == 10);
      Target   = (i == 3) ? 32'h40 : (i == 10) ? 32'h80 : 32'hDEAD_BEE0;
      @(negedge CLK);
      checks++;
      if ({Busy, Done, PCSrc} !== 3'b100) begin
        errors++;
        $display("FAIL div_exec_%0d: got busy/done/pcsrc=%b want 100", i, {Busy, Done, PCSrc});
      end
      step;
    end
    Redirect = 1'b0; Target = 32'd0;
    @(negedge CLK);
    checks++;
    if ({Busy, Done, PCSrc} !== 3'b011 || Result !== 32'h80) begin
      errors++;
      $display("FAIL div_release: got busy/done/pcsrc=%b result=%h want 011 result=80",
               {Busy, Done, PCSrc}, Result);
    end
    step;
    @(negedge CLK);
    checks++;
    if (PCSrc !== 1'b0 || Result !== 32'd0) begin
      errors++;
      $display("FAIL div_after_release: got pcsrc=%b result=%h want 0/0", PCSrc, Result);
    end
  endtask

  task automatic test_live_override;
    step;
    Start = 1'b1;
    step;
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      Redirect = (i == 2);
      Target   = (i == 2) ? 32'h80 : 32'd0;
      step;
    end
    Redirect = 1'b1; Target = 32'hC0;
    @(negedge CLK);
    checks++;
    if ({Done, PCSrc} !== 2'b11 || Result !== 32'hC0) begin
      errors++;
      $display("FAIL live_override: got done/pcsrc=%b result=%h want 11 result=c0",
               {Done, PCSrc}, Result);
    end
    step;
    Redirect = 1'b0; Target = 32'd0;
    @(negedge CLK);
    checks++;
    if (PCSrc !== 1'b0 || Result !== 32'd0) begin
      errors++;
      $display("FAIL live_override_discard: got pcsrc=%b result=%h want 0/0", PCSrc, Result);
    end
  endtask

  task automatic test_memwait;
    step;
    Start = 1'b1; IsDiv = 1'b0;
    step;
    Start = 1'b0; MemWait = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      checks++;
      if (Busy !== 1'b1 || Done !== (i == 5)) begin
        errors++;
        $display("FAIL memwait_%0d: got busy=%b done=%b want busy=1 done=%b",
                 i, Busy, Done, (i == 5));
      end
      step;
    end
    MemWait = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Busy, Done} !== 2'b00) begin
      errors++;
      $display("FAIL memwait_clear: got busy/done=%b want 00", {Busy, Done});
    end
  endtask

  task automatic test_back_to_back;
    step;
    Start = 1'b1;
    step;
    Start = 1'b0;
    repeat (4) step;
    Start = 1'b1;
    @(negedge CLK);
    checks++;
    if ({Busy, Done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: got busy/done=%b want 01", {Busy, Done});
    end
    step;
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({Busy, Done} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_exec_%0d: got busy/done=%b want 10", i, {Busy, Done});
      end
      step;
    end
    @(negedge CLK);
    checks++;
    if ({Busy, Done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_second_done: got busy/done=%b want 01", {Busy, Done});
    end
    step;
  endtask

  task automatic test_reset_mid;
    step;
    Start = 1'b1;
    step;
    Start = 1'b0; Redirect = 1'b1; Target = 32'h44;
    step;
    Redirect = 1'b0; Target = 32'd0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Busy, PCSrc, Done, Trap} !== 4'b0000 || Result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got busy/pcsrc/done/trap=%b result=%h want 0000 result=0",
               {Busy, PCSrc, Done, Trap}, Result);
    end
    #1 Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step;
      @(negedge CLK);
      checks++;
      if ({Busy, PCSrc, Done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_after_%0d: got busy/pcsrc/done=%b want 000",
                 i, {Busy, PCSrc, Done});
      end
    end
  endtask

  task automatic test_misalign;
    step;
    Redirect = 1'b1; Target = 32'h42;
    @(negedge CLK);
    checks++;
    if (PCSrc !== 1'b1 || Result !== ExpMisResult || Trap !== ExpMisTrap) begin
      errors++;
      $display("FAIL misalign_live: got pcsrc=%b result=%h trap=%b want 1 %h %b",
               PCSrc, Result, Trap, ExpMisResult, ExpMisTrap);
    end
    Target = 32'h44;
    #1;
    checks++;
    if (PCSrc !== 1'b1 || Result !== 32'h44 || Trap !== 1'b0) begin
      errors++;
      $display("FAIL aligned_live: got pcsrc=%b result=%h trap=%b want 1 44 0",
               PCSrc, Result, Trap);
    end
    step;
    Redirect = 1'b0; Target = 32'd0;
    @(negedge CLK);
    checks++;
    if (PCSrc !== 1'b0 || Trap !== 1'b0) begin
      errors++;
      $display("FAIL misalign_quiet: got pcsrc=%b trap=%b want 0 0", PCSrc, Trap);
    end
    // Misaligned target buffered during a stall is checked only when released.
    step;
    Start = 1'b1;
    step;
    Start = 1'b0; Redirect = 1'b1; Target = 32'h42;
    step;
    Redirect = 1'b0; Target = 32'd0;
    repeat (3) step;
    @(negedge CLK);
    checks++;
    if (PCSrc !== 1'b1 || Result !== ExpMisResult || Trap !== ExpMisTrap) begin
      errors++;
      $display("FAIL misalign_pending: got pcsrc=%b result=%h trap=%b want 1 %h %b",
               PCSrc, Result, Trap, ExpMisResult, ExpMisTrap);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div_redirect;
    test_live_override;
    test_memwait;
    test_back_to_back;
    test_reset_mid;
    test_misalign;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_stall_sequencer.md
# pc_stall_sequencer

Sequencer that drives the program counter's `Busy` and `PCSrc`/`Result` controls. It holds the PC for the duration of multi-cycle multiply/divide operations and for memory wait states. It buffers branch/jump redirects that arrive while the PC is held, then releases them when the stall ends. It sits between decode/execute and the program counter register.

## Interface
- `MUL_CYCLES`, 4, stall length in cycles for a multiply (legal 1..63)
- `DIV_CYCLES`, 33, stall length in cycles for a divide (legal 1..63)
- `TRAP_VECTOR`, 32'h0000_0100, redirect address used for misaligned targets (see Configuration)

- `CLK`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Start`  in  1  decode issues a multi-cycle op this cycle
- `IsDiv`  in  1  qualifies `Start`: 1 = divide, 0 = multiply
- `MemWait`  in  1  data memory not ready; PC must hold
- `Redirect`  in  1  branch taken / jump this cycle
- `Target`  in  32  redirect address, valid with `Redirect`
- `Busy`  out  1  to PC: hold current value
- `PCSrc`  out  1  to PC: load `Result`
- `Result`  out  32  redirect address to PC; 32'b0 when `PCSrc`=0
- `Done`  out  1  one-cycle pulse: multi-cycle op finished
- `Trap`  out  1  misaligned redirect replaced by `TRAP_VECTOR`

## Operation
- FSM states:
  - IDLE: reset state.
  - EXEC: counting the stall.
  - DONE: one cycle, `Done`=1.
- IDLE or DONE with `Start`=1:
  - Go to EXEC.
  - Load `cnt` with (`IsDiv` ? `DIV_CYCLES` : `MUL_CYCLES`) − 1.
- IDLE or DONE with `Start`=0: go to IDLE.
- EXEC:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`==0: go to DONE.
  - `Start` is ignored in EXEC.
- `cnt` is 6 bits, unsigned, and never wraps; it is only decremented while nonzero.
- `Busy` = (state==EXEC) | `MemWait`. This is combinational from registered state plus the `MemWait` input.
- Redirect handling, evaluated every cycle:
  - `Busy`=0 and `Redirect`=1: `PCSrc`=1, `Result`=`Target`. Any pending redirect is discarded, because the live redirect is younger.
  - `Busy`=0, `Redirect`=0, pending valid: `PCSrc`=1, `Result`=pending target. Pending is cleared at the edge.
  - `Busy`=1 and `Redirect`=1: capture `Target` into the pending register and set pending valid. An existing pending entry is overwritten (youngest wins). `PCSrc`=0.
  - `Busy`=1 and `Redirect`=0: pending is held. `PCSrc`=0.
- `Start` and `Redirect` in the same non-busy cycle are both honoured. The redirect goes out that cycle and the stall begins next cycle.
- `MemWait` during EXEC does not pause `cnt`. `Busy` simply stays high until both conditions clear.
- Reset mid-EXEC:
  - Aborts immediately: state IDLE, `cnt`=0, pending cleared.
  - No `Done` pulse.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, pending valid=0, pending target=0.
  - `Busy`=`MemWait`, `PCSrc`=0, `Result`=0, `Done`=0, `Trap`=0.
- Start latency: with `Start` sampled at edge k, `Busy`=1 for exactly N cycles (k+1 … k+N), where N is the selected cycle count. `Done`=1 in cycle k+N+1, and `Busy`=0 there unless `MemWait`=1.
- Back-to-back ops: `Start` during the `Done` cycle gives `Busy` high again from the next cycle, leaving one unstalled cycle between ops.
- A pending redirect is released in the first cycle with `Busy`=0. That cycle is combinational, with no added latency.
- `PCSrc`, `Result` and `Trap` are combinational from inputs and registered state. `Done` is decoded from registered state.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Whenever `PCSrc`=1 and the selected address has [1:0]≠2'b00, `Result`=`TRAP_VECTOR` and `Trap`=1 for that cycle.
  - The pending register stores the raw target; the check is applied at release.
- `MISALIGN_TRAP_EN` undefined:
  - The target passes through unchanged.
  - `Trap` is tied to 0 and the port remains present.

## Test plan
- Reset, then `Start`=1 with `IsDiv`=0 → `Busy`=1 for exactly 4 cycles, `Done` pulses 1 cycle on the 5th cycle, `PCSrc`=0 throughout.
- `Start` with `IsDiv`=1; `Redirect`=1 with `Target`=32'h40 on EXEC cycle 3, then `Redirect`=1 with `Target`=32'h80 on EXEC cycle 10 → `Busy` high 33 cycles. In the first non-busy cycle, `PCSrc`=1 and `Result`=32'h80, then `PCSrc`=0 next cycle.
- Pending 32'h80 held, then live `Redirect` with `Target`=32'hC0 in the release cycle → `Result`=32'hC0, pending discarded, no second `PCSrc` pulse.
- `MemWait`=1 for 6 cycles overlapping a 4-cycle multiply → `Busy` stays high until `MemWait` falls. `Done` still occurs 5 cycles after `Start`.
- `Reset` asserted on EXEC cycle 2 with a pending redirect → all outputs return to reset values asynchronously. No `Done` and no `PCSrc` afterwards.
- With `MISALIGN_TRAP_EN`, idle `Redirect` with `Target`=32'h42 → `PCSrc`=1, `Result`=32'h100, `Trap`=1. Without the macro → `Result`=32'h42, `Trap`=0.
